pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised successor to the 8-bit program counter.
- Holds the fetch address and supports:
  - variable-length increment
  - jump/branch
  - vector load from memory data
  - hardware call/return through an internal return-address stack (RAS)
- Sits between the control FSM and the instruction-memory address port.
- Reports stack status and a sticky stack-error flag to the control unit.

Parameters:
AW, 8, PC and address width in bits (>=4).
RAS_DEPTH, 4, number of return-address stack entries (>=1).
RESET_PC, 0, value loaded into pc_out on reset (AW bits).
DW_LEN, 2, width of inc_len.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
pc_write  in  1  when 1, the operation on pc_op executes this edge; when 0, all state holds.
pc_op  in  3  0=INC, 1=JUMP, 2=VECTOR, 3=CALL, 4=RET; 5..7 reserved and behave as hold.
inc_len  in  DW_LEN  instruction length used by INC and as the CALL return offset.
pc_target  in  AW  branch, jump or call destination.
mem_data  in  AW  vector word read from M[0] or M[1].
clr_err  in  1  clears stk_err.
pc_out  out  AW  current PC, registered.
ras_top  out  AW  top-of-stack value; don't-care when stk_empty.
ras_count  out  clog2(RAS_DEPTH+1)  occupied entries.
stk_full  out  1  ras_count == RAS_DEPTH.
stk_empty  out  1  ras_count == 0.
stk_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, rst_n=0):
  - pc_out=RESET_PC, ras_count=0, stk_err=0.
  - RAS storage is not reset.
  - Takes effect immediately, including mid-operation; the first update occurs on the first rising edge after deassertion.
- All outputs are registered; every operation has 1-cycle latency (the result is visible after the edge).
- Arithmetic is modulo 2^AW. inc_len is zero-extended; wrap-around at 2^AW-1 is silent.
- pc_write=0: pc_out, RAS and ras_count hold. stk_err changes only via clr_err.
- INC: pc_out <= pc_out + inc_len. inc_len=0 is a legal hold.
- JUMP: pc_out <= pc_target.
- VECTOR: pc_out <= mem_data. The RAS is untouched.
- CALL:
  - Not full: push (pc_out + inc_len) mod 2^AW, ras_count+1, pc_out <= pc_target.
  - Full: overflow. No push, pc_out holds, stk_err <= 1.
- RET:
  - Not empty: pc_out <= ras_top, ras_count-1.
  - Empty: underflow. pc_out holds, stk_err <= 1.
- Reserved pc_op with pc_write=1: hold; no error.
- Only one operation per cycle; pc_op encoding makes ops mutually exclusive.
- clr_err and a new error on the same edge: the error wins (stk_err=1).
- ras_top, stk_full and stk_empty are derived combinationally from the registered count and storage, so they are glitch-free relative to clk.

Decomposition:
- Shared package pc_pkg holds:
  - PC_OP_INC/JUMP/VECTOR/CALL/RET localparams
  - PC_OP_W=3
- One sub-module, ras_lifo, parametrised by AW and RAS_DEPTH:
  - Ports: push, pop, din, top, count, full, empty.
  - Ignores push when full and pop when empty.
  - pc_sequencer owns the error logic.

Test Plan (AW=8, RAS_DEPTH=4, RESET_PC=0):
1. Reset and vector: assert rst_n=0 mid-cycle -> pc_out=00 before the next edge. Release, then VECTOR with mem_data=10 -> pc_out=10.
2. Variable increment: INC inc_len=1 -> 11; INC inc_len=2 -> 13; INC inc_len=0 -> 13; pc_write=0 for 2 cycles -> 13.
3. Call/return nest: at pc=20, CALL len=2 target=50 -> pc=50, ras_top=22, count=1. At 50, CALL len=1 target=80 -> pc=80, ras_top=51. RET -> 51. RET -> 22, stk_empty=1.
4. Overflow: 4 CALLs -> stk_full=1. 5th CALL target=AA -> pc unchanged, count=4, stk_err=1. clr_err with no op -> stk_err=0.
5. Underflow and priority: with RAS empty, RET with clr_err=1 on the same edge -> pc unchanged, stk_err=1.
6. Wrap-around: JUMP FF, then INC len=2 -> 01. JUMP FE, then CALL len=2 target=40 -> ras_top=00. Reserved op 7 -> hold, no error.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: operation encoding.
package pc_pkg;
   localparam int PC_OP_W = 3;
   localparam logic [PC_OP_W-1:0] PC_OP_INC    = 3'd0;
   localparam logic [PC_OP_W-1:0] PC_OP_JUMP   = 3'd1;
   localparam logic [PC_OP_W-1:0] PC_OP_VECTOR = 3'd2;
   localparam logic [PC_OP_W-1:0] PC_OP_CALL   = 3'd3;
   localparam logic [PC_OP_W-1:0] PC_OP_RET    = 3'd4;
endpackage

// File: rtl/pc_sequencer_ras_lifo.sv
// Return-address stack: a small LIFO that ignores push when full and pop when empty.
module ras_lifo #(
   parameter int AW        = 8,
   parameter int RAS_DEPTH = 4,
   localparam int CW       = $clog2(RAS_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] top,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   logic [AW-1:0] mem_q [RAS_DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic          push_ok_s, pop_ok_s;

   assign full      = (count_q == CW'(RAS_DEPTH));
   assign empty     = (count_q == {CW{1'b0}});
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign count     = count_q;

   // Occupancy next-state; a simultaneous push and pop leaves the count unchanged.
   always_comb begin
      count_d = count_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= {CW{1'b0}};
      else        count_q <= count_d;
   end

   // Entry storage carries no reset; only the slot at the current count is written.
   always_ff @(posedge clk) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
         if (push_ok_s && !pop_ok_s && count_q == CW'(i)) mem_q[i] <= din;
      end
   end

   // Top-of-stack selection from registered count and storage.
   always_comb begin
      top = {AW{1'b0}};
      for (int i = 0; i < RAS_DEPTH; i++) begin
         if (count_q == CW'(i + 1)) top = mem_q[i];
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter with variable increment, jump, vector load and hardware call/return.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int            AW        = 8,
   parameter int            RAS_DEPTH = 4,
   parameter logic [AW-1:0] RESET_PC  = '0,
   parameter int            DW_LEN    = 2,
   localparam int           CW        = $clog2(RAS_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pc_write,
   input  logic [PC_OP_W-1:0] pc_op,
   input  logic [DW_LEN-1:0]  inc_len,
   input  logic [AW-1:0]      pc_target,
   input  logic [AW-1:0]      mem_data,
   input  logic               clr_err,
   output logic [AW-1:0]      pc_out,
   output logic [AW-1:0]      ras_top,
   output logic [CW-1:0]      ras_count,
   output logic               stk_full,
   output logic               stk_empty,
   output logic               stk_err
);
   logic [AW-1:0] pc_q, pc_d, inc_sum_s;
   logic          err_q, err_d, err_set_s, push_s, pop_s;

   assign inc_sum_s = pc_q + AW'(inc_len);

   // Operation decode: next PC, stack controls and error detection.
   always_comb begin
      pc_d      = pc_q;
      push_s    = 1'b0;
      pop_s     = 1'b0;
      err_set_s = 1'b0;
      if (pc_write) begin
         case (pc_op)
            PC_OP_INC:    pc_d = inc_sum_s;
            PC_OP_JUMP:   pc_d = pc_target;
            PC_OP_VECTOR: pc_d = mem_data;
            PC_OP_CALL: begin
               if (stk_full) begin
                  err_set_s = 1'b1;
               end else begin
                  push_s = 1'b1;
                  pc_d   = pc_target;
               end
            end
            PC_OP_RET: begin
               if (stk_empty) begin
                  err_set_s = 1'b1;
               end else begin
                  pop_s = 1'b1;
                  pc_d  = ras_top;
               end
            end
            default: pc_d = pc_q;
         endcase
      end else begin
         pc_d = pc_q;
      end
      // A new error on the same edge beats the clear request.
      if (err_set_s)    err_d = 1'b1;
      else if (clr_err) err_d = 1'b0;
      else              err_d = err_q;
   end

   // PC and sticky error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_PC;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
      end
   end

   ras_lifo #(.AW(AW), .RAS_DEPTH(RAS_DEPTH)) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .din   (inc_sum_s),
      .top   (ras_top),
      .count (ras_count),
      .full  (stk_full),
      .empty (stk_empty)
   );

   assign pc_out  = pc_q;
   assign stk_err = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with AW=8, RAS_DEPTH=4, RESET_PC=0.
module tb_pc_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       pc_write;
   logic [2:0] pc_op;
   logic [1:0] inc_len;
   logic [7:0] pc_target, mem_data;
   logic       clr_err;
   logic [7:0] pc_out, ras_top;
   logic [2:0] ras_count;
   logic       stk_full, stk_empty, stk_err;
   int         checks = 0;
   int         errors = 0;

   pc_sequencer #(.AW(8), .RAS_DEPTH(4), .RESET_PC(8'h00), .DW_LEN(2)) dut (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_op(pc_op),
      .inc_len(inc_len), .pc_target(pc_target), .mem_data(mem_data),
      .clr_err(clr_err), .pc_out(pc_out), .ras_top(ras_top),
      .ras_count(ras_count), .stk_full(stk_full), .stk_empty(stk_empty),
      .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one operation at the falling edge and return 1 time unit after the rising edge.
   task automatic step(input logic wr, input logic [2:0] op, input logic [1:0] len,
                       input logic [7:0] tgt, input logic [7:0] md, input logic clr);
      @(negedge clk);
      pc_write = wr; pc_op = op; inc_len = len; pc_target = tgt; mem_data = md; clr_err = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; pc_write = 1'b0; pc_op = 3'd0; inc_len = 2'd0;
      pc_target = 8'h00; mem_data = 8'h00; clr_err = 1'b0;
      #12 rst_n = 1'b1;
      chk("reset_pc", 32'(pc_out), 32'h00);
      chk("reset_empty", 32'(stk_empty), 32'h1);

      // 1. mid-cycle reset and vector load
      step(1'b1, 3'd2, 2'd0, 8'h00, 8'h5C, 1'b0);
      chk("vector_pre", 32'(pc_out), 32'h5C);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_pc", 32'(pc_out), 32'h00);
      chk("async_reset_err", 32'(stk_err), 32'h0);
      chk("async_reset_cnt", 32'(ras_count), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      step(1'b1, 3'd2, 2'd0, 8'h00, 8'h10, 1'b0);
      chk("vector", 32'(pc_out), 32'h10);

      // 2. variable increment and hold
      step(1'b1, 3'd0, 2'd1, 8'h00, 8'h00, 1'b0);
      chk("inc1", 32'(pc_out), 32'h11);
      step(1'b1, 3'd0, 2'd2, 8'h00, 8'h00, 1'b0);
      chk("inc2", 32'(pc_out), 32'h13);
      step(1'b1, 3'd0, 2'd0, 8'h00, 8'h00, 1'b0);
      chk("inc0", 32'(pc_out), 32'h13);
      step(1'b0, 3'd0, 2'd3, 8'h00, 8'h00, 1'b0);
      step(1'b0, 3'd1, 2'd3, 8'h77, 8'h00, 1'b0);
      chk("hold", 32'(pc_out), 32'h13);

      // 3. nested call/return
      step(1'b1, 3'd1, 2'd0, 8'h20, 8'h00, 1'b0);
      chk("jump20", 32'(pc_out), 32'h20);
      step(1'b1, 3'd3, 2'd2, 8'h50, 8'h00, 1'b0);
      chk("call1_pc", 32'(pc_out), 32'h50);
      chk("call1_top", 32'(ras_top), 32'h22);
      chk("call1_cnt", 32'(ras_count), 32'h1);
      step(1'b1, 3'd3, 2'd1, 8'h80, 8'h00, 1'b0);
      chk("call2_pc", 32'(pc_out), 32'h80);
      chk("call2_top", 32'(ras_top), 32'h51);
      step(1'b1, 3'd4, 2'd0, 8'h00, 8'h00, 1'b0);
      chk("ret1_pc", 32'(pc_out), 32'h51);
      chk("ret1_top", 32'(ras_top), 32'h22);
      step(1'b1, 3'd4, 2'd0, 8'h00, 8'h00, 1'b0);
      chk("ret2_pc", 32'(pc_out), 32'h22);
      chk("ret2_empty", 32'(stk_empty), 32'h1);

      // 4. overflow
      step(1'b1, 3'd3, 2'd1, 8'h30, 8'h00, 1'b0);
      step(1'b1, 3'd3, 2'd1, 8'h40, 8'h00, 1'b0);
      step(1'b1, 3'd3, 2'd1, 8'h50, 8'h00, 1'b0);
      chk("fill_full_early", 32'(stk_full), 32'h0);
      step(1'b1, 3'd3, 2'd1, 8'h60, 8'h00, 1'b0);
      chk("fill_full", 32'(stk_full), 32'h1);
      chk("fill_pc", 32'(pc_out), 32'h60);
      step(1'b1, 3'd3, 2'd1, 8'hAA, 8'h00, 1'b0);
      chk("ovf_pc", 32'(pc_out), 32'h60);
      chk("ovf_cnt", 32'(ras_count), 32'h4);
      chk("ovf_err", 32'(stk_err), 32'h1);
      chk("ovf_top", 32'(ras_top), 32'h51);
      step(1'b0, 3'd0, 2'd0, 8'h00, 8'h00, 1'b1);
      chk("clr_err", 32'(stk_err), 32'h0);
      step(1'b1, 3'd4, 2'd0, 8'h00, 8'h00, 1'b0);
      chk("unwind1", 32'(pc_out), 32'h51);
      step(1'b1, 3'd4, 2'd0, 8'h00, 8'h00, 1'b0);
      chk("unwind2", 32'(pc_out), 32'h41);
      step(1'b1, 3'd4, 2'd0, 8'h00, 8'h00, 1'b0);
      chk("unwind3", 32'(pc_out), 32'h31);
      step(1'b1, 3'd4, 2'd0, 8'h00, 8'h00, 1'b0);
      chk("unwind4", 32'(pc_out), 32'h23);
      chk("unwind_empty", 32'(stk_empty), 32'h1);

      // 5. underflow with simultaneous clear: error wins
      step(1'b1, 3'd4, 2'd0, 8'h00, 8'h00, 1'b1);
      chk("unf_pc", 32'(pc_out), 32'h23);
      chk("unf_err", 32'(stk_err), 32'h1);
      chk("unf_cnt", 32'(ras_count), 32'h0);
      step(1'b0, 3'd0, 2'd0, 8'h00, 8'h00, 1'b1);
      chk("unf_clr", 32'(stk_err), 32'h0);

      // 6. wrap-around and reserved ops
      step(1'b1, 3'd1, 2'd0, 8'hFF, 8'h00, 1'b0);
      step(1'b1, 3'd0, 2'd2, 8'h00, 8'h00, 1'b0);
      chk("wrap_inc", 32'(pc_out), 32'h01);
      step(1'b1, 3'd1, 2'd0, 8'hFE, 8'h00, 1'b0);
      step(1'b1, 3'd3, 2'd2, 8'h40, 8'h00, 1'b0);
      chk("wrap_call_pc", 32'(pc_out), 32'h40);
      chk("wrap_call_top", 32'(ras_top), 32'h00);
      step(1'b1, 3'd7, 2'd3, 8'h99, 8'h88, 1'b0);
      chk("rsv7_pc", 32'(pc_out), 32'h40);
      chk("rsv7_err", 32'(stk_err), 32'h0);
      chk("rsv7_cnt", 32'(ras_count), 32'h1);
      step(1'b1, 3'd5, 2'd3, 8'h99, 8'h88, 1'b0);
      chk("rsv5_pc", 32'(pc_out), 32'h40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
